// File: rtl/controlador_exibicao_if.sv
// ---------------------------------------------------------------------------
// controlador_exibicao_if
// Groups the control handshake, the sequence-memory read port and the
// display/status outputs of controlador_exibicao. The controller connects
// through the slave modport. The host side (start/abort source and the
// combinational sequence memory) connects through the master modport.
// ---------------------------------------------------------------------------
interface controlador_exibicao_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    // Host -> controller
    logic              iniciar;       // start playback request
    logic              cancelar;      // synchronous abort
    logic [ADDR_W-1:0] limite;        // last address to play, inclusive
    logic [DATA_W-1:0] mem_dado;      // combinational read data for mem_endereco

    // Controller -> host
    logic [ADDR_W-1:0] mem_endereco;  // registered memory address
    logic [DATA_W-1:0] leds;          // registered LED drive
    logic              ocupado;       // high whenever not idle
    logic              pronto;        // one-cycle completion pulse
    logic [3:0]        db_estado;     // current state code

    modport master (
        output iniciar, cancelar, limite, mem_dado,
        input  mem_endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, cancelar, limite, mem_dado,
        output mem_endereco, leds, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/controlador_exibicao.sv
// ---------------------------------------------------------------------------
// controlador_exibicao
// Plays a sequence of LED words read from an external combinational memory,
// from address 0 up to a limit address latched at start. Each word is lit
// for T_ACESO cycles. When the macro EXIBICAO_PAUSA_EN is defined, each word
// is followed by T_APAGADO blank cycles. In the default build (macro
// undefined) there is no blank gap, and the LEDs keep the previous word until
// the next one is loaded.
//
// State sequence per word:
//   CARREGA -> ACESO [-> APAGADO] -> AVANCA (more words) | FIM (last word)
// FIM raises pronto for one cycle and returns to OCIOSO. cancelar wins over
// every transition and returns to OCIOSO without a pronto pulse.
// ---------------------------------------------------------------------------
module controlador_exibicao #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 250
) (
    input  logic                   clock,
    input  logic                   reset,   // asynchronous, active low
    controlador_exibicao_if.slave  bus
);

    // State codes
    localparam logic [3:0] OCIOSO  = 4'd0;
    localparam logic [3:0] CARREGA = 4'd1;
    localparam logic [3:0] ACESO   = 4'd2;
    localparam logic [3:0] APAGADO = 4'd3;
    localparam logic [3:0] AVANCA  = 4'd4;
    localparam logic [3:0] FIM     = 4'd5;

    // The timer is sized for the longer of the two phases. It counts
    // 0..T-1 and is cleared before it could wrap.
    localparam int T_MAX   = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TIMER_W-1:0] ACESO_ULT   = TIMER_W'(T_ACESO - 1);
`ifdef EXIBICAO_PAUSA_EN
    localparam logic [TIMER_W-1:0] APAGADO_ULT = TIMER_W'(T_APAGADO - 1);
`endif

    logic [3:0]         estado_q,   estado_d;
    logic [ADDR_W-1:0]  endereco_q, endereco_d;
    logic [ADDR_W-1:0]  limite_q,   limite_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [DATA_W-1:0]  leds_q,     leds_d;
    logic               pronto_q,   pronto_d;

    logic ultimo_endereco;
    logic timer_aceso_fim;

    assign ultimo_endereco = (endereco_q == limite_q);
    assign timer_aceso_fim = (timer_q == ACESO_ULT);

    // Next-state, address, timer and LED computation
    always_comb begin
        // NOTE: every signal written here gets a default first, so a missed
        // branch holds the flop value instead of inferring a latch.
        estado_d   = estado_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        timer_d    = timer_q;
        leds_d     = leds_q;

        if (bus.cancelar) begin
            // Abort has priority over every transition. In OCIOSO this also
            // masks a simultaneous iniciar. The address keeps its value
            // because the next start clears it anyway.
            estado_d = OCIOSO;
            leds_d   = '0;
            timer_d  = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        estado_d   = CARREGA;
                        endereco_d = '0;
                        limite_d   = bus.limite;
                        timer_d    = '0;
                    end
                end

                CARREGA: begin
                    // The memory address is already stable, so load the word.
                    estado_d = ACESO;
                    leds_d   = bus.mem_dado;
                    timer_d  = '0;
                end

                ACESO: begin
                    if (timer_aceso_fim) begin
                        timer_d = '0;
`ifdef EXIBICAO_PAUSA_EN
                        leds_d   = '0;
                        estado_d = APAGADO;
`else
                        // No blank gap: decide directly. The LEDs hold the
                        // word through AVANCA/CARREGA and are cleared only
                        // when the sequence finishes.
                        if (ultimo_endereco) begin
                            estado_d = FIM;
                            leds_d   = '0;
                        end else begin
                            estado_d = AVANCA;
                        end
`endif
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

`ifdef EXIBICAO_PAUSA_EN
                APAGADO: begin
                    if (timer_q == APAGADO_ULT) begin
                        timer_d  = '0;
                        estado_d = ultimo_endereco ? FIM : AVANCA;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
`endif

                AVANCA: begin
                    // Never reached on the last address, so this cannot wrap.
                    endereco_d = endereco_q + 1'b1;
                    estado_d   = CARREGA;
                end

                FIM: begin
                    // The address keeps its last value for inspection.
                    estado_d = OCIOSO;
                end

                default: begin
                    // Unused codes (and APAGADO when the gap is compiled out)
                    // recover to idle.
                    estado_d = OCIOSO;
                    leds_d   = '0;
                    timer_d  = '0;
                end
            endcase
        end

        // pronto is registered and is high exactly while the state is FIM.
        pronto_d = (estado_d == FIM);
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            limite_q   <= '0;
            timer_q    <= '0;
            leds_q     <= '0;
            pronto_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values of the previous cycle regardless of statement order.
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            timer_q    <= timer_d;
            leds_q     <= leds_d;
            pronto_q   <= pronto_d;
        end
    end

    assign bus.mem_endereco = endereco_q;
    assign bus.leds         = leds_q;
    assign bus.pronto       = pronto_q;
    assign bus.ocupado      = (estado_q != OCIOSO);
    assign bus.db_estado    = estado_q;

endmodule
